// File: rtl/edge_pkg.sv
// Shared types for the edge generator and the edge detector benches.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE_LO,
        IDLE_HI,
        HOLD_LO,
        HOLD_HI
    } edge_state_t;

    typedef enum logic {
        DIR_FALL,
        DIR_RISE
    } edge_dir_t;

    // Output level implied by a state.
    function automatic logic is_hi(input edge_state_t s);
        return (s == IDLE_HI) || (s == HOLD_HI);
    endfunction

endpackage

// File: rtl/edge_gen_if.sv
// Request/level bundle of the edge generator.
// Optional echo outputs are present when EDGE_GEN_ECHO_EN is defined.
interface edge_gen_if;
    logic rise_req;
    logic fall_req;
    logic d_out;
    logic busy;
    logic pending;
    logic drop_err;
`ifdef EDGE_GEN_ECHO_EN
    logic rise_echo;
    logic fall_echo;
`endif

    // Requester side.
    modport master (
        output rise_req, fall_req,
`ifdef EDGE_GEN_ECHO_EN
        input  rise_echo, fall_echo,
`endif
        input  d_out, busy, pending, drop_err
    );

    // Generator side.
    modport slave (
        input  rise_req, fall_req,
`ifdef EDGE_GEN_ECHO_EN
        output rise_echo, fall_echo,
`endif
        output d_out, busy, pending, drop_err
    );
endinterface

// File: rtl/edge_hold_cnt.sv
// Hold counter: loads MIN_HOLD-1 on a transition, counts down to zero,
// and reports busy while nonzero.
module edge_hold_cnt #(
    parameter int MIN_HOLD = 3,
    localparam int CNT_W = $clog2(MIN_HOLD + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MIN_HOLD - 1);

    logic [CNT_W-1:0] cnt_q;

    // Load on transition, otherwise saturating decrement toward zero.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    // NOTE: async reset clears the counter immediately, abandoning any hold in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/edge_gen.sv
// Edge generator: turns rise/fall request pulses into a held level with
// a one-deep queue for opposite requests that arrive during a hold.
// Optional feature: EDGE_GEN_ECHO_EN adds rise_echo/fall_echo pulses.
module edge_gen
    import edge_pkg::*;
#(
    parameter int MIN_HOLD = 3
) (
    input logic       clk,
    input logic       rst,
    edge_gen_if.slave bus
);

    edge_state_t state_q, state_d;
    edge_dir_t   pdir_q, pdir_d;
    logic        pend_q, pend_d;
    logic        drop_q, drop_d;
    logic        d_q, lvl_d;
    logic        load;
    logic        busy_w;

    logic open, level, both, live_rise, live_fall, opp_req;
    edge_dir_t opp_dir;

    edge_hold_cnt #(.MIN_HOLD(MIN_HOLD)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .busy (busy_w)
    );

    assign open      = ~busy_w;
    assign level     = is_hi(state_q);
    assign both      = bus.rise_req & bus.fall_req;
    assign live_rise = bus.rise_req & ~bus.fall_req;
    assign live_fall = bus.fall_req & ~bus.rise_req;
    assign opp_req   = level ? live_fall : live_rise;
    assign opp_dir   = level ? DIR_FALL : DIR_RISE;

    // Next state: pending service first, then live request against the resulting level.
    // NOTE: every variable gets a default at the top so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        pdir_d  = pdir_q;
        drop_d  = both;
        lvl_d   = level;
        load    = 1'b0;
        if (open) begin
            if (pend_q) begin
                lvl_d  = (pdir_q == DIR_RISE);
                load   = 1'b1;
                pend_d = 1'b0;
                // A matching live request is absorbed; an opposite one is re-queued.
                if (lvl_d ? live_fall : live_rise) begin
                    pend_d = 1'b1;
                    pdir_d = lvl_d ? DIR_FALL : DIR_RISE;
                end
            end else if (opp_req) begin
                lvl_d = ~level;
                load  = 1'b1;
            end
        end else if (opp_req) begin
            if (!pend_q) begin
                pend_d = 1'b1;
                pdir_d = opp_dir;
            end else begin
                drop_d = 1'b1;
            end
        end
        if (load) begin
            state_d = lvl_d ? HOLD_HI : HOLD_LO;
        end else if (open) begin
            state_d = level ? IDLE_HI : IDLE_LO;
        end
    end

    // State, level, queue and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LO;
            pend_q  <= 1'b0;
            pdir_q  <= DIR_FALL;
            drop_q  <= 1'b0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            pdir_q  <= pdir_d;
            drop_q  <= drop_d;
            d_q     <= lvl_d;
        end
    end

    assign bus.d_out    = d_q;
    assign bus.busy     = busy_w;
    assign bus.pending  = pend_q;
    assign bus.drop_err = drop_q;

`ifdef EDGE_GEN_ECHO_EN
    logic rise_echo_q, fall_echo_q;

    // Echo pulses coincide with the first cycle d_out shows the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_echo_q <= 1'b0;
            fall_echo_q <= 1'b0;
        end else begin
            rise_echo_q <= load & lvl_d;
            fall_echo_q <= load & ~lvl_d;
        end
    end

    assign bus.rise_echo = rise_echo_q;
    assign bus.fall_echo = fall_echo_q;
`endif

endmodule
